serial_borrow_select_sub: RTL and testbench

SERIAL_BORROW_SELECT_SUB -- requirements
Module: serial_borrow_select_sub

---
 rtl/serial_borrow_select_sub.sv | 95 +++++++++
 tb/tb_serial_borrow_select_sub.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/serial_borrow_select_sub.sv
// Nibble-serial 16-bit subtractor: one borrow-select nibble per cycle, five-cycle turnaround.
// Optional SUB_SAT_EN: an underflowing result is clamped to zero.
module serial_borrow_select_sub (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        b_in,
    output logic        busy,
    output logic        done,
    output logic [15:0] d,
    output logic        b_out
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state;
    state_t      state_next;
    logic [15:0] a_r;
    logic [15:0] b_r;
    logic        borrow;
    logic [1:0]  cnt;
    logic        accept;
    logic [3:0]  a_nib;
    logic [3:0]  b_nib;
    logic [4:0]  diff0;
    logic [4:0]  diff1;
    logic [3:0]  nib_sel;
    logic        bor_sel;

    assign accept = start && (state != RUN);

    // Both borrow cases are computed up front; the registered borrow only drives the mux.
    always_comb begin
        a_nib   = a_r[{cnt, 2'b00} +: 4];
        b_nib   = b_r[{cnt, 2'b00} +: 4];
        diff0   = {1'b0, a_nib} - {1'b0, b_nib};
        diff1   = {1'b0, a_nib} - {1'b0, b_nib} - 5'd1;
        nib_sel = borrow ? diff1[3:0] : diff0[3:0];
        bor_sel = borrow ? diff1[4] : diff0[4];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: if (start) state_next = RUN;
            RUN: begin
                busy = 1'b1;
                if (cnt == 2'd3) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = start ? RUN : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r    <= 16'h0000;
            b_r    <= 16'h0000;
            borrow <= 1'b0;
            cnt    <= 2'd0;
            d      <= 16'h0000;
            b_out  <= 1'b0;
        end else if (accept) begin
            a_r    <= a;
            b_r    <= b;
            borrow <= b_in;
            cnt    <= 2'd0;
            d      <= 16'h0000;
            b_out  <= 1'b0;
        end else if (state == RUN) begin
            d[{cnt, 2'b00} +: 4] <= nib_sel;
            borrow <= bor_sel;
            cnt    <= cnt + 2'd1;
            if (cnt == 2'd3) begin
                b_out <= bor_sel;
`ifdef SUB_SAT_EN
                if (bor_sel) d <= 16'h0000;
`endif
            end
        end
    end

endmodule

// File: tb/tb_serial_borrow_select_sub.sv
// Directed bench for serial_borrow_select_sub with a result scoreboard.
module tb_serial_borrow_select_sub;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [15:0] a = 16'h0000;
    logic [15:0] b = 16'h0000;
    logic        b_in = 1'b0;
    logic        busy;
    logic        done;
    logic [15:0] d;
    logic        b_out;

    int          vectors = 0;
    int          miscompares = 0;
    logic [16:0] sb[$];

    serial_borrow_select_sub dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .b_in  (b_in),
        .busy  (busy),
        .done  (done),
        .d     (d),
        .b_out (b_out)
    );

    always #5 clk = ~clk;

    function automatic logic [16:0] model(input logic [15:0] av, input logic [15:0] bv,
                                          input logic bi);
        logic [16:0] m;
        m = {1'b0, av} - {1'b0, bv} - {16'h0000, bi};
`ifdef SUB_SAT_EN
        if (m[16]) m[15:0] = 16'h0000;
`endif
        return m;
    endfunction

    task automatic chk(input string tag, input logic [16:0] obs, input logic [16:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic apply(input logic [15:0] av, input logic [15:0] bv, input logic bi);
        @(negedge clk);
        start = 1'b1;
        a     = av;
        b     = bv;
        b_in  = bi;
        sb.push_back(model(av, bv, bi));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic await_done(input string tag, input int exp_lat);
        int lat;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done) begin
                lat = i;
                break;
            end
        end
        chk({tag, "_lat"}, 17'(lat), 17'(exp_lat));
        chk({tag, "_busy"}, {16'h0000, busy}, 17'h0);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 17'h1, 17'h0);
        end else begin
            chk(tag, {b_out, d}, sb.pop_front());
        end
    endtask

    task automatic count_done(input string tag, input int cycles);
        int n;
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done) n++;
        end
        chk(tag, 17'(n), 17'h0);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #2;
        chk("rst_busy", {16'h0000, busy}, 17'h0);
        chk("rst_done", {16'h0000, done}, 17'h0);
        chk("rst_res", {b_out, d}, 17'h0);
        @(negedge clk);
        rst_n = 1'b1;

        apply(16'h1234, 16'h0034, 1'b0);
        chk("run_busy", {16'h0000, busy}, 17'h1);
        await_done("ex1234", 4);

        apply(16'h0000, 16'h0001, 1'b0);
        await_done("underflow", 4);
        @(negedge clk);
        @(negedge clk);
        chk("hold_res", {b_out, d}, model(16'h0000, 16'h0001, 1'b0));
        chk("hold_done", {16'h0000, done}, 17'h0);

        apply(16'h1000, 16'h0000, 1'b1);
        await_done("ripple", 4);

        // start re-pulsed mid-run with different operands
        apply(16'h00FF, 16'h0010, 1'b0);
        @(negedge clk);
        start = 1'b1;
        a     = 16'hAAAA;
        b     = 16'h5555;
        b_in  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        await_done("ignore", 2);
        count_done("ignore_extra", 8);

        // reset pulse once two nibbles are done
        apply(16'h4321, 16'h1234, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", {16'h0000, busy}, 17'h0);
        chk("midrst_res", {b_out, d}, 17'h0);
        void'(sb.pop_front());
        @(negedge clk);
        rst_n = 1'b1;
        count_done("midrst_nodone", 8);
        apply(16'h8000, 16'h0001, 1'b0);
        await_done("after_rst", 4);

        // start held high: back-to-back operations
        @(negedge clk);
        start = 1'b1;
        a     = 16'hFFFF;
        b     = 16'h0001;
        b_in  = 1'b0;
        sb.push_back(model(16'hFFFF, 16'h0001, 1'b0));
        @(negedge clk);
        a = 16'h0005;
        b = 16'h0005;
        sb.push_back(model(16'h0005, 16'h0005, 1'b0));
        await_done("b2b_first", 4);
        @(negedge clk);
        start = 1'b0;
        await_done("b2b_second", 4);

        for (int i = 0; i < 6; i++) begin
            logic [15:0] ra;
            logic [15:0] rb;
            logic        rc;
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom_range(0, 1));
            apply(ra, rb, rc);
            await_done("rand", 4);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
